// File: rtl/gather_pkg.sv
// ----------------------------------------------------------------------------
// gather_pkg
//   Shared definitions for the C2H gather stage: FSM state encoding, the width
//   of the packet-total field and the header field offsets.
//   No ports (package).
// ----------------------------------------------------------------------------
package gather_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_TARGET = 3'd1,
    ST_HEADER = 3'd2,
    ST_DATA   = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // The packet total always occupies the top 32 bits of the header beat.
  localparam int TOTAL_WIDTH = 32;

  // Per-column lengths are packed from bit 0 of the header beat upwards.
  localparam int LEN_LSB = 0;

  // MSB of the total field for a given stream width.
  function automatic int total_msb(input int data_width);
    return data_width - 1;
  endfunction

endpackage

// File: rtl/gather_next_col_sel.sv
// ----------------------------------------------------------------------------
// gather_next_col_sel
//   Combinational priority finder over the latched per-column lengths.
//   Returns the lowest-numbered column with a nonzero length that is either
//   anywhere (start_flag_i=1) or strictly above cur_idx_i (start_flag_i=0).
// Ports
//   lens_i        in   N*LW  packed lengths, col i at [i*LW +: LW]
//   cur_idx_i     in   IW    column currently being drained
//   start_flag_i  in   1     search from column 0 inclusive
//   next_idx_o    out  IW    selected column (0 when none found)
//   found_o       out  1     a qualifying column exists
// ----------------------------------------------------------------------------
module gather_next_col_sel #(
  parameter int N  = 4,
  parameter int LW = 16,
  parameter int IW = 2
) (
  input  logic [N*LW-1:0] lens_i,
  input  logic [IW-1:0]   cur_idx_i,
  input  logic            start_flag_i,
  output logic [IW-1:0]   next_idx_o,
  output logic            found_o
);

  logic [N-1:0] eligible;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_elig
      assign eligible[gi] = (lens_i[gi*LW +: LW] != '0) &&
                            (start_flag_i || (gi > int'(cur_idx_i)));
    end
  endgenerate

  // Scan downwards so the lowest eligible index wins.
  always_comb begin
    next_idx_o = '0;
    found_o    = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        next_idx_o = IW'(i);
        found_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gather.sv
// ----------------------------------------------------------------------------
// gather
//   Drains per-column FWFT result FIFOs into a single C2H AXI-stream packet:
//   beat 0 echoes the target word, beat 1 carries the packet total and the
//   per-column lengths, then column payloads follow in column order.
//   Columns with zero length are skipped entirely.
// Ports
//   user_clk           in   1                 clock, rising edge
//   user_rst           in   1                 async reset, active low
//   collect_start      in   1                 pulse: begin one packet (IDLE only)
//   target_i           in   ALIGN_BITS        target word for beat 0
//   res_len            in   COL_MAX_SIZE*LW   beats per column
//   res_fifo_dout      in   COL_MAX_SIZE*DW   FWFT FIFO heads
//   res_fifo_empty     in   COL_MAX_SIZE      FIFO empty flags
//   res_fifo_rd_en     out  COL_MAX_SIZE      one-hot pop strobe
//   m_axis_c2h_*       out/in                 AXI-stream master
//   gather_busy        out  1                 packet in progress
//   gather_done        out  1                 one-cycle completion pulse
// TCQ is a simulation-only clock-to-q figure and is not applied here.
// ----------------------------------------------------------------------------
module gather
  import gather_pkg::*;
#(
  parameter int TCQ             = 1,
  parameter int DATA_WIDTH      = 128,
  parameter int BYTE_BIT_ENABLE = DATA_WIDTH / 8,
  parameter int COL_MAX_SIZE    = 4,
  parameter int ALIGN_BITS      = 128,
  parameter int LEN_WIDTH       = 16
) (
  input  logic                               user_clk,
  input  logic                               user_rst,
  input  logic                               collect_start,
  input  logic [ALIGN_BITS-1:0]              target_i,
  input  logic [COL_MAX_SIZE*LEN_WIDTH-1:0]  res_len,
  input  logic [COL_MAX_SIZE*DATA_WIDTH-1:0] res_fifo_dout,
  input  logic [COL_MAX_SIZE-1:0]            res_fifo_empty,
  output logic [COL_MAX_SIZE-1:0]            res_fifo_rd_en,
  output logic [DATA_WIDTH-1:0]              m_axis_c2h_tdata,
  output logic [BYTE_BIT_ENABLE-1:0]         m_axis_c2h_tkeep,
  output logic                               m_axis_c2h_tlast,
  output logic                               m_axis_c2h_tvalid,
  input  logic                               m_axis_c2h_tready,
  output logic                               gather_busy,
  output logic                               gather_done
);

  localparam int COL_IDX_W = (COL_MAX_SIZE > 1) ? $clog2(COL_MAX_SIZE) : 1;
  localparam int LEN_BITS  = COL_MAX_SIZE * LEN_WIDTH;
  localparam int TOTAL_MSB = total_msb(DATA_WIDTH);

  logic unused_tcq;
  assign unused_tcq = (TCQ != 0);

  state_e                 state_q;
  logic [ALIGN_BITS-1:0]  target_q;
  logic [LEN_BITS-1:0]    len_q;
  logic [TOTAL_WIDTH-1:0] total_q;
  logic [TOTAL_WIDTH-1:0] total_d;
  logic [COL_IDX_W-1:0]   col_q;
  logic [LEN_WIDTH-1:0]   beat_cnt_q;
  logic                   busy_q;

  logic [DATA_WIDTH-1:0]  dout_arr [COL_MAX_SIZE];
  logic [LEN_WIDTH-1:0]   len_arr  [COL_MAX_SIZE];
  logic [DATA_WIDTH-1:0]  header_word;
  logic [COL_IDX_W-1:0]   sel_idx;
  logic                   sel_found;
  logic                   accept;

  // Zero-extended sum of the incoming lengths, latched on start.
  always_comb begin
    total_d = '0;
    for (int i = 0; i < COL_MAX_SIZE; i++) begin
      total_d = total_d + TOTAL_WIDTH'(res_len[i*LEN_WIDTH +: LEN_WIDTH]);
    end
  end

  generate
    for (genvar gi = 0; gi < COL_MAX_SIZE; gi++) begin : g_col
      assign dout_arr[gi]       = res_fifo_dout[gi*DATA_WIDTH +: DATA_WIDTH];
      assign len_arr[gi]        = len_q[gi*LEN_WIDTH +: LEN_WIDTH];
      // accept already implies the current column's FIFO is non-empty.
      assign res_fifo_rd_en[gi] = (state_q == ST_DATA) &&
                                  (col_q == COL_IDX_W'(gi)) && accept;
    end
  endgenerate

  // In HEADER the search starts at column 0; in DATA it looks strictly above
  // the current column, which also answers "is this the last column?".
  gather_next_col_sel #(
    .N  (COL_MAX_SIZE),
    .LW (LEN_WIDTH),
    .IW (COL_IDX_W)
  ) u_next_col_sel (
    .lens_i       (len_q),
    .cur_idx_i    (col_q),
    .start_flag_i (state_q != ST_DATA),
    .next_idx_o   (sel_idx),
    .found_o      (sel_found)
  );

  always_comb begin
    header_word = '0;
    header_word[TOTAL_MSB -: TOTAL_WIDTH] = total_q;
    header_word[LEN_LSB +: LEN_BITS]      = len_q;
  end

  // Stream outputs are decoded from registered state; in DATA, tvalid follows
  // the FWFT empty flag directly, which cannot rise again without a pop.
  always_comb begin
    m_axis_c2h_tvalid = 1'b0;
    m_axis_c2h_tdata  = '0;
    m_axis_c2h_tlast  = 1'b0;
    case (state_q)
      ST_TARGET: begin
        m_axis_c2h_tvalid = 1'b1;
        m_axis_c2h_tdata  = DATA_WIDTH'(target_q);
      end
      ST_HEADER: begin
        m_axis_c2h_tvalid = 1'b1;
        m_axis_c2h_tdata  = header_word;
        m_axis_c2h_tlast  = (total_q == '0);
      end
      ST_DATA: begin
        m_axis_c2h_tvalid = ~res_fifo_empty[col_q];
        m_axis_c2h_tdata  = dout_arr[col_q];
        m_axis_c2h_tlast  = (beat_cnt_q == LEN_WIDTH'(1)) && !sel_found;
      end
      default: ;
    endcase
  end

  assign accept           = m_axis_c2h_tvalid & m_axis_c2h_tready;
  assign m_axis_c2h_tkeep = {BYTE_BIT_ENABLE{m_axis_c2h_tvalid}};
  assign gather_busy      = busy_q;
  assign gather_done      = (state_q == ST_DONE);

  always_ff @(posedge user_clk or negedge user_rst) begin
    if (!user_rst) begin
      state_q    <= ST_IDLE;
      target_q   <= '0;
      len_q      <= '0;
      total_q    <= '0;
      col_q      <= '0;
      beat_cnt_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (collect_start) begin
            target_q <= target_i;
            len_q    <= res_len;
            total_q  <= total_d;
            busy_q   <= 1'b1;
            state_q  <= ST_TARGET;
          end
        end
        ST_TARGET: begin
          if (accept) state_q <= ST_HEADER;
        end
        ST_HEADER: begin
          if (accept) begin
            if (total_q == '0) begin
              state_q <= ST_DONE;
            end else begin
              col_q      <= sel_idx;
              beat_cnt_q <= len_arr[sel_idx];
              state_q    <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (accept) begin
            if (beat_cnt_q == LEN_WIDTH'(1)) begin
              if (sel_found) begin
                col_q      <= sel_idx;
                beat_cnt_q <= len_arr[sel_idx];
              end else begin
                beat_cnt_q <= '0;
                state_q    <= ST_DONE;
              end
            end else begin
              beat_cnt_q <= beat_cnt_q - LEN_WIDTH'(1);
            end
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gather.sv
// ----------------------------------------------------------------------------
// tb_gather
//   Scoreboard bench for gather. Stimulus preloads a FIFO model, pushes the
//   expected beats into a queue and pulses collect_start; an independent
//   monitor pops and compares every accepted stream beat.
// ----------------------------------------------------------------------------
module tb_gather;

  logic         user_clk = 1'b0;
  logic         user_rst = 1'b0;
  logic         collect_start = 1'b0;
  logic [127:0] target_i = '0;
  logic [63:0]  res_len = '0;
  logic [511:0] res_fifo_dout;
  logic [3:0]   res_fifo_empty;
  logic [3:0]   res_fifo_rd_en;
  logic [127:0] m_axis_c2h_tdata;
  logic [15:0]  m_axis_c2h_tkeep;
  logic         m_axis_c2h_tlast;
  logic         m_axis_c2h_tvalid;
  logic         m_axis_c2h_tready = 1'b1;
  logic         gather_busy;
  logic         gather_done;

  gather dut (
    .user_clk          (user_clk),
    .user_rst          (user_rst),
    .collect_start     (collect_start),
    .target_i          (target_i),
    .res_len           (res_len),
    .res_fifo_dout     (res_fifo_dout),
    .res_fifo_empty    (res_fifo_empty),
    .res_fifo_rd_en    (res_fifo_rd_en),
    .m_axis_c2h_tdata  (m_axis_c2h_tdata),
    .m_axis_c2h_tkeep  (m_axis_c2h_tkeep),
    .m_axis_c2h_tlast  (m_axis_c2h_tlast),
    .m_axis_c2h_tvalid (m_axis_c2h_tvalid),
    .m_axis_c2h_tready (m_axis_c2h_tready),
    .gather_busy       (gather_busy),
    .gather_done       (gather_done)
  );

  always #5 user_clk = ~user_clk;

  int checks = 0;
  int errors = 0;
  int beats = 0;
  int pops = 0;
  int done_cnt = 0;
  int cyc = 0;
  int last_cyc = -10;
  int b0, p0, d0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] mkword(input int c, input int i);
    return {32'hA5A5_0000 + 32'(c), 64'h0, 32'h0000_1000 + 32'(i)};
  endfunction

  // ---------------- FWFT FIFO model ----------------
  logic [127:0] fq [4][$];
  logic [511:0] dout_q = '0;
  logic [3:0]   empty_q = 4'hF;
  logic [3:0]   block = 4'h0;

  always @(posedge user_clk) begin
    for (int c = 0; c < 4; c++) begin
      if (res_fifo_rd_en[c] && fq[c].size() > 0) void'(fq[c].pop_front());
      dout_q[c*128 +: 128] <= (fq[c].size() > 0) ? fq[c][0] : 128'h0;
      empty_q[c]           <= (fq[c].size() == 0);
    end
  end

  assign res_fifo_dout  = dout_q;
  assign res_fifo_empty = empty_q | block;

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [127:0] data;
    logic         last;
    int           col;
  } beat_t;

  beat_t        exp_q[$];
  logic         prev_stall = 1'b0;
  logic [127:0] prev_data = '0;

  always @(negedge user_clk) begin
    beat_t e;
    logic [3:0] er;
    cyc++;
    if (user_rst) begin
      if (prev_stall) begin
        chk("hold_tvalid", 128'(m_axis_c2h_tvalid), 128'd1);
        chk("hold_tdata", m_axis_c2h_tdata, prev_data);
      end
      if (m_axis_c2h_tvalid && m_axis_c2h_tready) begin
        beats++;
        pops += $countones(res_fifo_rd_en);
        $display("beat %0d data=%h last=%0b rd_en=%b", beats, m_axis_c2h_tdata,
                 m_axis_c2h_tlast, res_fifo_rd_en);
        if (exp_q.size() == 0) begin
          chk("beat_expected", 128'd1, 128'd0);
        end else begin
          e  = exp_q.pop_front();
          er = (e.col < 0) ? 4'd0 : (4'd1 << e.col);
          chk("tdata", m_axis_c2h_tdata, e.data);
          chk("tlast", 128'(m_axis_c2h_tlast), 128'(e.last));
          chk("rd_en", 128'(res_fifo_rd_en), 128'(er));
          chk("tkeep", 128'(m_axis_c2h_tkeep), 128'hFFFF);
        end
        if (m_axis_c2h_tlast) last_cyc = cyc;
      end else if (|res_fifo_rd_en) begin
        chk("rd_en_without_accept", 128'(res_fifo_rd_en), 128'd0);
      end
      if (gather_done) begin
        done_cnt++;
        chk("done_latency", 128'(cyc), 128'(last_cyc + 1));
      end
      prev_stall = m_axis_c2h_tvalid && !m_axis_c2h_tready;
      prev_data  = m_axis_c2h_tdata;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic preload(input logic [63:0] lens);
    for (int c = 0; c < 4; c++)
      for (int i = 0; i < int'(lens[c*16 +: 16]); i++) fq[c].push_back(mkword(c, i));
    repeat (2) @(posedge user_clk);
  endtask

  task automatic expect_packet(input logic [127:0] tgt, input logic [63:0] lens,
                               input logic [127:0] hdr);
    int last_c = -1;
    int n;
    exp_q.push_back('{data: tgt, last: 1'b0, col: -1});
    exp_q.push_back('{data: hdr, last: (hdr[127:96] == 32'd0), col: -1});
    for (int c = 0; c < 4; c++) if (lens[c*16 +: 16] != 16'd0) last_c = c;
    for (int c = 0; c < 4; c++) begin
      n = int'(lens[c*16 +: 16]);
      for (int i = 0; i < n; i++)
        exp_q.push_back('{data: mkword(c, i), last: (c == last_c) && (i == n - 1), col: c});
    end
  endtask

  task automatic begin_pkt(input logic [127:0] tgt, input logic [63:0] lens,
                           input logic [127:0] hdr);
    b0 = beats; p0 = pops; d0 = done_cnt;
    preload(lens);
    expect_packet(tgt, lens, hdr);
    @(posedge user_clk); #1;
    target_i = tgt; res_len = lens; collect_start = 1'b1;
    @(posedge user_clk); #1;
    collect_start = 1'b0; target_i = ~tgt; res_len = '1;
    chk("busy_after_start", 128'(gather_busy), 128'd1);
  endtask

  task automatic wait_beats(input int n);
    int k = 0;
    while (beats < b0 + n && k < 300) begin @(posedge user_clk); k++; end
    chk("beat_reached", 128'(beats - b0), 128'(n));
  endtask

  task automatic finish_pkt(input int exp_beats);
    int k = 0;
    while (done_cnt == d0 && k < 300) begin @(negedge user_clk); k++; end
    chk("done_pulses", 128'(done_cnt - d0), 128'd1);
    @(negedge user_clk);
    chk("busy_after_done", 128'(gather_busy), 128'd0);
    chk("beat_count", 128'(beats - b0), 128'(exp_beats));
    chk("pop_count", 128'(pops - p0), 128'(exp_beats - 2));
    chk("scoreboard_drained", 128'(exp_q.size()), 128'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_tvalid"}, 128'(m_axis_c2h_tvalid), 128'd0);
    chk({tag, "_tlast"}, 128'(m_axis_c2h_tlast), 128'd0);
    chk({tag, "_tdata"}, m_axis_c2h_tdata, 128'd0);
    chk({tag, "_rd_en"}, 128'(res_fifo_rd_en), 128'd0);
    chk({tag, "_busy"}, 128'(gather_busy), 128'd0);
    chk({tag, "_done"}, 128'(gather_done), 128'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic stop;
    #2;
    check_idle_outputs("reset");
    repeat (3) @(posedge user_clk);
    #1 user_rst = 1'b1;
    repeat (2) @(posedge user_clk);

    // 1: lens {3,0,2,1}, tready held high
    begin_pkt(128'hDEAD_BEEF_0123_4567_89AB_CDEF_0000_0001, 64'h0001_0002_0000_0003,
              128'h0000_0006_0000_0000_0001_0002_0000_0003);
    finish_pkt(8);

    // 2: all lengths zero -> target + header only, header carries tlast
    begin_pkt(128'h1111_2222_3333_4444_5555_6666_7777_8888, 64'h0,
              128'h0);
    finish_pkt(2);

    // 3: lens {1,1,1,1} with tready toggling
    begin_pkt(128'hCAFE_0000_0000_0000_0000_0000_0000_0003, 64'h0001_0001_0001_0001,
              128'h0000_0004_0000_0000_0001_0001_0001_0001);
    stop = 1'b0;
    fork
      begin finish_pkt(6); stop = 1'b1; end
      begin
        while (!stop) begin @(posedge user_clk); #1 m_axis_c2h_tready = ~m_axis_c2h_tready; end
      end
    join
    m_axis_c2h_tready = 1'b1;

    // 4: col1 FIFO goes empty for 5 cycles after its first beat
    begin_pkt(128'h4444_0000_0000_0000_0000_0000_0000_0004, 64'h0000_0000_0003_0000,
              128'h0000_0003_0000_0000_0000_0000_0003_0000);
    wait_beats(3);
    #1 block = 4'b0010;
    repeat (5) begin
      @(negedge user_clk);
      chk("stall_tvalid", 128'(m_axis_c2h_tvalid), 128'd0);
      chk("stall_rd_en", 128'(res_fifo_rd_en), 128'd0);
    end
    @(posedge user_clk); #1 block = 4'b0000;
    finish_pkt(5);

    // 5: reset while beat 4 of 8 is presented
    begin_pkt(128'h5555_0000_0000_0000_0000_0000_0000_0005, 64'h0001_0002_0000_0003,
              128'h0000_0006_0000_0000_0001_0002_0000_0003);
    wait_beats(3);
    #1 user_rst = 1'b0;
    #1 check_idle_outputs("midreset");
    exp_q.delete();
    for (int c = 0; c < 4; c++) fq[c].delete();
    repeat (2) @(posedge user_clk);
    @(negedge user_clk) user_rst = 1'b1;
    chk("no_done_after_abort", 128'(done_cnt - d0), 128'd0);
    begin_pkt(128'h5555_AAAA_0000_0000_0000_0000_0000_0006, 64'h0000_0000_0000_0002,
              128'h0000_0002_0000_0000_0000_0000_0000_0002);
    finish_pkt(4);

    // 6: second start pulse while busy must be ignored
    begin_pkt(128'h6666_0000_0000_0000_0000_0000_0000_0007, 64'h0000_0001_0000_0001,
              128'h0000_0002_0000_0000_0000_0001_0000_0001);
    wait_beats(2);
    #1 target_i = 128'hBAD0; res_len = 64'h0000_0000_0000_0005; collect_start = 1'b1;
    @(posedge user_clk); #1 collect_start = 1'b0;
    finish_pkt(4);
    repeat (10) @(negedge user_clk);
    chk("single_done", 128'(done_cnt - d0), 128'd1);
    chk("single_packet", 128'(beats - b0), 128'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
